// File: rtl/matrix_entry_ctrl.sv
// matrix_entry_ctrl: collects a cfgX x cfgY matrix one element per beat and commits it to a store with a single strobe.
// Defining MATRIX_ENTRY_TIMEOUT_EN adds a 16-bit LOAD inactivity timeout.
module matrix_entry_ctrl #(
  parameter int ELEM_WIDTH = 8,
  parameter int MAX_DIM    = 5
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic [7:0]                              cfgX,
  input  logic [7:0]                              cfgY,
  input  logic                                    abort,
  input  logic                                    elemValid,
  input  logic [ELEM_WIDTH-1:0]                   elemData,
  output logic                                    elemReady,
  output logic [7:0]                              dimX,
  output logic [7:0]                              dimY,
  output logic                                    writeEnable,
  output logic [MAX_DIM*MAX_DIM*ELEM_WIDTH-1:0]   writeData,
  output logic [4:0]                              elemCnt,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    err
);
  localparam int MAX_ELEM = MAX_DIM * MAX_DIM;
  localparam logic [7:0] MD = 8'(MAX_DIM);

  typedef enum logic [1:0] {IDLE, LOAD, ALIGN, COMMIT} state_t;

  state_t                             r_state, w_next;
  logic [7:0]                         r_dim_x, r_dim_y;
  logic [MAX_ELEM*ELEM_WIDTH-1:0]     r_data;
  logic [4:0]                         r_cnt;
  logic                               r_err;
  logic                               w_ok, w_accept, w_beat, w_last, w_tmo;
  logic [7:0]                         w_total;

  assign w_ok     = (cfgX != 8'd0) && (cfgX <= MD) && (cfgY != 8'd0) && (cfgY <= MD);
  assign w_accept = (r_state == IDLE) && start && w_ok;
  assign w_beat   = elemValid && elemReady;
  assign w_total  = 8'(r_dim_x * r_dim_y);
  assign w_last   = w_beat && (({3'b0, r_cnt} + 8'd1) == w_total);

`ifdef MATRIX_ENTRY_TIMEOUT_EN
  logic [15:0] r_tmo;
  // Counter idles at zero outside LOAD, so it is already clear on entry.
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_tmo <= '0;
    else      r_tmo <= (r_state != LOAD || w_beat) ? '0 : r_tmo + 16'd1;
  assign w_tmo = (r_state == LOAD) && !w_beat && (r_tmo == 16'hFFFF);
`else
  assign w_tmo = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? LOAD : IDLE;
      LOAD:    w_next = abort ? IDLE : w_last ? ALIGN : w_tmo ? IDLE : LOAD;
      ALIGN:   w_next = COMMIT;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= IDLE;
      r_dim_x <= '0;
      r_dim_y <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= ((r_state == IDLE) && start && !w_ok) || (w_tmo && !abort);
      if (w_accept) begin
        r_dim_x <= cfgX;
        r_dim_y <= cfgY;
        r_data  <= '0;
        r_cnt   <= '0;
      end else if (w_beat) begin
        r_cnt <= r_cnt + 5'd1;
        for (int k = 0; k < MAX_ELEM; k++)
          if (r_cnt == 5'(k)) r_data[k*ELEM_WIDTH +: ELEM_WIDTH] <= elemData;
      end
    end

  assign elemReady   = (r_state == LOAD);
  assign writeEnable = (r_state == COMMIT);
  assign done        = (r_state == COMMIT);
  assign busy        = (r_state != IDLE);
  assign err         = r_err;
  assign dimX        = r_dim_x;
  assign dimY        = r_dim_y;
  assign writeData   = r_data;
  assign elemCnt     = r_cnt;
endmodule

// File: doc/matrix_entry_ctrl.md
MATRIX_ENTRY_CTRL -- requirements
Module: matrix_entry_ctrl

Interface
REQ-001 SHALL have parameter ELEM_WIDTH, default 8, bits per matrix element.
REQ-002 SHALL have parameter MAX_DIM, default 5, maximum rows/columns; MAX_ELEM = MAX_DIM*MAX_DIM = 25.
REQ-003 SHALL have ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin entry session, 1-cycle pulse.
- cfgX  in  8  requested column count, sampled on accepted start.
- cfgY  in  8  requested row count, sampled on accepted start.
- abort  in  1  cancel session.
- elemValid  in  1  element beat valid.
- elemData  in  ELEM_WIDTH  element value.
- elemReady  out  1  controller accepts beat.
- dimX  out  8  column count to matrix store.
- dimY  out  8  row count to matrix store.
- writeEnable  out  1  single-cycle store write strobe.
- writeData  out  MAX_ELEM*ELEM_WIDTH  packed matrix; element k at bits [k*ELEM_WIDTH +: ELEM_WIDTH].
- elemCnt  out  5  elements accepted this session.
- busy  out  1  high in any state except IDLE.
- done  out  1  1-cycle pulse, matrix committed.
- err  out  1  1-cycle pulse, rejected start or timeout.

Function
REQ-004 SHALL implement FSM states IDLE, LOAD, ALIGN, COMMIT.
REQ-005 IDLE: start with 1<=cfgX<=MAX_DIM and 1<=cfgY<=MAX_DIM SHALL latch dims, clear writeData and elemCnt to 0, go to LOAD next cycle.
REQ-006 IDLE: start with either dim out of range SHALL pulse err next cycle, stay IDLE, leave dimX/dimY/writeData unchanged.
REQ-007 start outside IDLE SHALL be ignored.
REQ-008 dimX/dimY SHALL output latched dims from the cycle after accepted start and hold them until the next accepted start.
REQ-009 LOAD: elemReady SHALL be 1; a beat transfers when elemValid && elemReady on a clock edge.
REQ-010 Each transferred beat SHALL write elemData into element index elemCnt (row-major, index = row*cfgX + col) and increment elemCnt.
REQ-011 When the transferred beat makes elemCnt equal cfgX*cfgY, FSM SHALL go to ALIGN; elements >= cfgX*cfgY remain 0.
REQ-012 elemReady SHALL be 0 in IDLE, ALIGN, COMMIT; elemValid there SHALL have no effect.
REQ-013 ALIGN SHALL last exactly 1 cycle with writeEnable 0, so the store sees stable dims before the strobe.
REQ-014 COMMIT SHALL last exactly 1 cycle with writeEnable 1 and writeData/dimX/dimY stable; done SHALL pulse in the same cycle; next state IDLE.
REQ-015 Latency: last beat edge to writeEnable high = 2 cycles; writeEnable SHALL never be high more than 1 consecutive cycle.
REQ-016 abort in LOAD SHALL return to IDLE next cycle with no writeEnable and no done; abort coinciding with the final beat SHALL win (no commit).
REQ-017 abort in IDLE, ALIGN or COMMIT SHALL be ignored.
REQ-018 writeData SHALL hold its value after COMMIT until the next accepted start.

Reset
REQ-019 rst low SHALL asynchronously force IDLE, all outputs 0 (dimX, dimY, writeData, elemCnt, elemReady, writeEnable, busy, done, err), any state including mid-LOAD.
REQ-020 First accepted start SHALL be the first clk edge with rst high and start high.

Configuration
REQ-021 With MATRIX_ENTRY_TIMEOUT_EN defined, a 16-bit counter SHALL clear on entering LOAD and on each transferred beat, increment otherwise in LOAD; reaching 65535 SHALL pulse err and return to IDLE with no write.
REQ-022 Without MATRIX_ENTRY_TIMEOUT_EN, no counter SHALL exist and LOAD SHALL wait indefinitely.

Verification
REQ-023 start cfgX=2 cfgY=3, 6 beats 1..6 back-to-back -> writeEnable 2 cycles after 6th beat, dimX=2 dimY=3, elements 0..5 = 1..6, elements 6..24 = 0, done with strobe.
REQ-024 start cfgX=0 cfgY=3, then cfgX=6 cfgY=1 -> err pulse each, busy stays 0, no writeEnable.
REQ-025 start 5x5, 25 beats with elemValid toggling every other cycle -> exactly 25 transfers, elemCnt=25, single writeEnable cycle.
REQ-026 start 3x3, 4 beats, abort high with 5th beat -> IDLE, no writeEnable, no done; new start 1x1 with one beat 0xAB -> element 0 = 0xAB, all others 0.
REQ-027 rst low during LOAD after 3 beats -> all outputs 0 immediately, IDLE; with MATRIX_ENTRY_TIMEOUT_EN, 65535 idle cycles in LOAD -> err pulse, IDLE, no write.
